// File: rtl/atm_pkg.sv
// Shared definitions for the ATM session controller: state encoding, ledger op codes, menu codes.
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PIN_ENTRY = 3'd1,
    ST_PIN_CHECK = 3'd2,
    ST_MENU      = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_RSP  = 3'd5,
    ST_LOCKOUT   = 3'd6,
    ST_END       = 3'd7
  } state_e;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;

  localparam logic [2:0] SEL_BAL   = 3'b001;
  localparam logic [2:0] SEL_RAPID = 3'b010;
  localparam logic [2:0] SEL_WDR   = 3'b011;
  localparam logic [2:0] SEL_DEP   = 3'b100;
  localparam logic [2:0] SEL_EXIT  = 3'b101;

  function automatic logic is_session(state_e s);
    return (s == ST_PIN_ENTRY) || (s == ST_PIN_CHECK) || (s == ST_MENU) ||
           (s == ST_ISSUE) || (s == ST_WAIT_RSP);
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Command/response handshake between the session controller and the ledger datapath.
interface atm_session_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [7:0] cmd_amount;
  logic       cmd_ready;
  logic       rsp_valid;
  logic       rsp_ok;

  modport master (output cmd_valid, cmd_op, cmd_amount, input cmd_ready, rsp_valid, rsp_ok);
  modport slave  (input cmd_valid, cmd_op, cmd_amount, output cmd_ready, rsp_valid, rsp_ok);
endinterface

// File: rtl/atm_session_timer.sv
// Loadable down-counter: clr forces zero, load sets the start value, done flags zero.
module atm_session_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// Session controller: card presence, PIN entry with lockout, menu decode and ledger command handshake.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter logic [15:0] PIN_VALUE      = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES    = 100_000_000,
  parameter logic [7:0]  RAPID_AMOUNT   = 8'd20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               card_valid,
  input  logic               digit_valid,
  input  logic [3:0]         digit,
  input  logic               enter_btn,
  input  logic               cancel_btn,
  input  logic               menu_go,
  input  logic [2:0]         menu_sel,
  input  logic [7:0]         amount,
  atm_session_ctrl_if.master ledger,
  output logic               session_active,
  output logic               locked,
  output logic               pin_err,
  output logic               timeout,
  output logic               txn_ok,
  output logic               txn_fail,
  output logic [1:0]         tries_left,
  output logic [2:0]         state_dbg
);

  localparam int unsigned TW = 32;
  localparam logic [TW-1:0] TO_LOAD    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] LK_LOAD    = TW'(LOCK_CYCLES - 1);
  localparam logic [1:0]    TRIES_INIT = 2'(MAX_TRIES);

  state_e      state, state_nxt;
  logic [15:0] pin_buf, pin_buf_nxt;
  logic [2:0]  pin_cnt, pin_cnt_nxt;
  logic [1:0]  tries_nxt;
  logic        card_gone, card_gone_nxt;
  logic [1:0]  op_nxt;
  logic [7:0]  amt_nxt;
  logic        pin_err_nxt, timeout_nxt, txn_ok_nxt, txn_fail_nxt;
  logic        activity;
  logic        idle_clr, idle_load, idle_done;
  logic        lock_clr, lock_load, lock_done;

  assign activity = digit_valid | enter_btn | cancel_btn | menu_go;

  // Inactivity restarts on every button event and on entering a timed state.
  assign idle_clr  = !((state_nxt == ST_PIN_ENTRY) || (state_nxt == ST_MENU));
  assign idle_load = (state_nxt != state) || activity;
  assign lock_clr  = (state_nxt != ST_LOCKOUT);
  assign lock_load = (state != ST_LOCKOUT);

  atm_session_timer #(.W(TW)) u_idle_tmr (
    .clk(clk), .rst(rst), .clr(idle_clr), .load(idle_load), .load_val(TO_LOAD), .done(idle_done)
  );

  atm_session_timer #(.W(TW)) u_lock_tmr (
    .clk(clk), .rst(rst), .clr(lock_clr), .load(lock_load), .load_val(LK_LOAD), .done(lock_done)
  );

  always_comb begin
    state_nxt     = state;
    pin_buf_nxt   = pin_buf;
    pin_cnt_nxt   = pin_cnt;
    tries_nxt     = tries_left;
    card_gone_nxt = card_gone;
    op_nxt        = ledger.cmd_op;
    amt_nxt       = ledger.cmd_amount;
    pin_err_nxt   = 1'b0;
    timeout_nxt   = 1'b0;
    txn_ok_nxt    = 1'b0;
    txn_fail_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        card_gone_nxt = 1'b0;
        if (card_valid) begin
          pin_buf_nxt = '0;
          pin_cnt_nxt = '0;
          state_nxt   = ST_PIN_ENTRY;
        end
      end
      ST_PIN_ENTRY: begin
        if (!card_valid) begin
          state_nxt = ST_END;
        end else if (cancel_btn) begin
          pin_buf_nxt = '0;
          pin_cnt_nxt = '0;
        end else if (enter_btn) begin
          state_nxt = ST_PIN_CHECK;
        end else if (digit_valid) begin
          if ((digit <= 4'd9) && (pin_cnt < 3'd4)) begin
            pin_buf_nxt = {pin_buf[11:0], digit};
            pin_cnt_nxt = pin_cnt + 3'd1;
          end
        end else if (idle_done) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_END;
        end
      end
      ST_PIN_CHECK: begin
        if (!card_valid) begin
          state_nxt = ST_END;
        end else if ((pin_cnt == 3'd4) && (pin_buf == PIN_VALUE)) begin
          tries_nxt = TRIES_INIT;
          state_nxt = ST_MENU;
        end else begin
          pin_err_nxt = 1'b1;
          pin_buf_nxt = '0;
          pin_cnt_nxt = '0;
          tries_nxt   = (tries_left != 2'd0) ? tries_left - 2'd1 : 2'd0;
          state_nxt   = (tries_left <= 2'd1) ? ST_LOCKOUT : ST_PIN_ENTRY;
        end
      end
      ST_MENU: begin
        if (!card_valid || cancel_btn) begin
          state_nxt = ST_END;
        end else if (menu_go) begin
          case (menu_sel)
            SEL_BAL: begin
              op_nxt = OP_INQ; amt_nxt = '0; state_nxt = ST_ISSUE;
            end
            SEL_RAPID: begin
              op_nxt = OP_WDR; amt_nxt = RAPID_AMOUNT; state_nxt = ST_ISSUE;
            end
            SEL_WDR: if (amount != 8'd0) begin
              op_nxt = OP_WDR; amt_nxt = amount; state_nxt = ST_ISSUE;
            end
            SEL_DEP: if (amount != 8'd0) begin
              op_nxt = OP_DEP; amt_nxt = amount; state_nxt = ST_ISSUE;
            end
            SEL_EXIT: state_nxt = ST_END;
            default: ;
          endcase
        end else if (idle_done) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_END;
        end
      end
      ST_ISSUE: begin
        // Card loss is remembered so the in-flight transaction still completes.
        if (!card_valid) card_gone_nxt = 1'b1;
        if (ledger.cmd_ready) state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (!card_valid) card_gone_nxt = 1'b1;
        if (ledger.rsp_valid) begin
          txn_ok_nxt   = ledger.rsp_ok;
          txn_fail_nxt = !ledger.rsp_ok;
          state_nxt    = (card_gone || !card_valid) ? ST_END : ST_MENU;
        end
      end
      ST_LOCKOUT: begin
        if (lock_done) begin
          tries_nxt = TRIES_INIT;
          state_nxt = ST_IDLE;
        end
      end
      ST_END: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      pin_buf           <= '0;
      pin_cnt           <= '0;
      tries_left        <= TRIES_INIT;
      card_gone         <= 1'b0;
      ledger.cmd_valid  <= 1'b0;
      ledger.cmd_op     <= OP_INQ;
      ledger.cmd_amount <= '0;
      session_active    <= 1'b0;
      locked            <= 1'b0;
      pin_err           <= 1'b0;
      timeout           <= 1'b0;
      txn_ok            <= 1'b0;
      txn_fail          <= 1'b0;
    end else begin
      state             <= state_nxt;
      pin_buf           <= pin_buf_nxt;
      pin_cnt           <= pin_cnt_nxt;
      tries_left        <= tries_nxt;
      card_gone         <= card_gone_nxt;
      ledger.cmd_valid  <= (state_nxt == ST_ISSUE);
      ledger.cmd_op     <= op_nxt;
      ledger.cmd_amount <= amt_nxt;
      session_active    <= is_session(state_nxt);
      locked            <= (state_nxt == ST_LOCKOUT);
      pin_err           <= pin_err_nxt;
      timeout           <= timeout_nxt;
      txn_ok            <= txn_ok_nxt;
      txn_fail          <= txn_fail_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Bench for atm_session_ctrl: vector table, multi-cycle sequences and a ledger command scoreboard.
module tb_atm_session_ctrl;

  localparam int TO_T   = 40;
  localparam int LOCK_T = 30;

  localparam int S_IDLE = 0, S_PIN = 1, S_CHK = 2, S_MENU = 3, S_ISSUE = 4,
                 S_WAIT = 5, S_LOCK = 6, S_END = 7;

  logic       clk, rst;
  logic       card_valid, digit_valid, enter_btn, cancel_btn, menu_go;
  logic [3:0] digit;
  logic [2:0] menu_sel;
  logic [7:0] amount;
  logic       session_active, locked, pin_err, timeout, txn_ok, txn_fail;
  logic [1:0] tries_left;
  logic [2:0] state_dbg;

  atm_session_ctrl_if bus ();

  atm_session_ctrl #(.TIMEOUT_CYCLES(TO_T), .LOCK_CYCLES(LOCK_T)) dut (
    .clk(clk), .rst(rst), .card_valid(card_valid), .digit_valid(digit_valid), .digit(digit),
    .enter_btn(enter_btn), .cancel_btn(cancel_btn), .menu_go(menu_go), .menu_sel(menu_sel),
    .amount(amount), .ledger(bus), .session_active(session_active), .locked(locked),
    .pin_err(pin_err), .timeout(timeout), .txn_ok(txn_ok), .txn_fail(txn_fail),
    .tries_left(tries_left), .state_dbg(state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       card, dv;
    logic [3:0] dg;
    logic       ent, can, mgo;
    logic [2:0] sel;
    logic [7:0] amt;
    logic       rdy, rv, rok;
    logic [2:0] st;
    logic       act;
    logic [1:0] tl;
    logic       pe, cv, tok, tfl;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         n;
  logic       seen;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic add(input int c, dv, dg, en, cn, mg, sl, am, rd, rv, ro,
                     input int st, ac, tl, pe, cv, to, tf);
    vec_t v;
    v.card = c[0];  v.dv = dv[0];  v.dg = dg[3:0];  v.ent = en[0];  v.can = cn[0];
    v.mgo = mg[0];  v.sel = sl[2:0]; v.amt = am[7:0]; v.rdy = rd[0]; v.rv = rv[0];
    v.rok = ro[0];  v.st = st[2:0];  v.act = ac[0]; v.tl = tl[1:0]; v.pe = pe[0];
    v.cv = cv[0];   v.tok = to[0];  v.tfl = tf[0];
    vecs.push_back(v);
  endtask

  // Expected ledger command for a menu request: {valid, op, amount}.
  function automatic logic [10:0] model_cmd(input logic [2:0] sel, input logic [7:0] amt);
    case (sel)
      3'b001:  return {1'b1, 2'b00, 8'd0};
      3'b010:  return {1'b1, 2'b10, 8'd20};
      3'b011:  return {(amt != 8'd0), 2'b10, amt};
      3'b100:  return {(amt != 8'd0), 2'b01, amt};
      default: return 11'd0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    digit_valid   = 1'b0;
    enter_btn     = 1'b0;
    cancel_btn    = 1'b0;
    menu_go       = 1'b0;
    bus.rsp_valid = 1'b0;
  endtask

  task automatic send_pin(input logic [15:0] p);
    for (int k = 3; k >= 0; k--) begin
      digit_valid = 1'b1;
      digit       = p[4*k +: 4];
      step();
    end
    enter_btn = 1'b1;
    step();
    step();
  endtask

  always @(negedge clk) begin : scoreboard
    logic [9:0] e;
    if (!rst && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_cmd", {bus.cmd_op, bus.cmd_amount}, 32'h3ff);
      end else begin
        e = sb_q.pop_front();
        chk("sb_cmd", {bus.cmd_op, bus.cmd_amount}, e);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       v;
    int         prev;
    logic [10:0] m;

    rst = 1'b1; card_valid = 0; digit_valid = 0; digit = 0; enter_btn = 0; cancel_btn = 0;
    menu_go = 0; menu_sel = 0; amount = 0;
    bus.cmd_ready = 0; bus.rsp_valid = 0; bus.rsp_ok = 0;
    step(); step();
    chk("rst_state", state_dbg, S_IDLE);
    chk("rst_levels", {session_active, locked, bus.cmd_valid}, 0);
    chk("rst_cmd", {bus.cmd_op, bus.cmd_amount}, 0);
    chk("rst_pulses", {pin_err, timeout, txn_ok, txn_fail}, 0);
    chk("rst_tries", tries_left, 3);
    rst = 1'b0;

    // c dv dg en cn mg sl am rd rv ro | st ac tl pe cv tok tfl
    add(1,0,0,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,1,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,2,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,3,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,4,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,0,0,1,0,0,0,0,0,0,0, S_CHK,1,3,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0, S_MENU,1,3,0,0,0,0);
    add(1,0,0,0,0,1,1,0,1,0,0, S_ISSUE,1,3,0,1,0,0);
    add(1,0,0,0,0,0,0,0,1,0,0, S_WAIT,1,3,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,1,1, S_MENU,1,3,0,0,1,0);
    add(1,0,0,0,0,0,0,0,0,0,0, S_MENU,1,3,0,0,0,0);
    add(1,0,0,0,0,1,4,0,0,0,0, S_MENU,1,3,0,0,0,0);
    add(1,0,0,0,0,1,7,9,0,0,0, S_MENU,1,3,0,0,0,0);
    add(1,0,0,0,0,1,2,0,1,0,0, S_ISSUE,1,3,0,1,0,0);
    add(1,0,0,0,0,0,0,0,1,0,0, S_WAIT,1,3,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,1,0, S_MENU,1,3,0,0,0,1);
    add(1,0,0,0,1,0,0,0,0,0,0, S_END,0,3,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0,0, S_IDLE,0,3,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,7,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,9,0,1,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,1,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,10,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,2,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,3,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,4,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,1,5,0,0,0,0,0,0,0,0, S_PIN,1,3,0,0,0,0);
    add(1,0,0,1,0,0,0,0,0,0,0, S_CHK,1,3,0,0,0,0);
    add(1,0,0,0,0,0,0,0,0,0,0, S_MENU,1,3,0,0,0,0);
    add(1,0,0,0,0,1,5,0,0,0,0, S_END,0,3,0,0,0,0);
    add(0,0,0,0,0,0,0,0,0,0,0, S_IDLE,0,3,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      card_valid = v.card; digit_valid = v.dv; digit = v.dg; enter_btn = v.ent;
      cancel_btn = v.can; menu_go = v.mgo; menu_sel = v.sel; amount = v.amt;
      bus.cmd_ready = v.rdy; bus.rsp_valid = v.rv; bus.rsp_ok = v.rok;
      prev = (i == 0) ? S_IDLE : int'(vecs[i-1].st);
      if (prev == S_MENU && v.card && !v.can && v.mgo) begin
        m = model_cmd(v.sel, v.amt);
        if (m[10]) sb_q.push_back(m[9:0]);
      end
      step();
      chk($sformatf("vec%0d", i),
          {state_dbg, session_active, tries_left, pin_err, bus.cmd_valid, txn_ok, txn_fail},
          {v.st, v.act, v.tl, v.pe, v.cv, v.tok, v.tfl});
    end
    bus.cmd_ready = 1'b0;

    // Three wrong PINs, then a full lockout; card pulled mid-lockout.
    card_valid = 1'b1;
    step();
    chk("lk_entry", state_dbg, S_PIN);
    for (int t = 0; t < 3; t++) begin
      send_pin(16'h1111);
      chk($sformatf("wrong%0d_perr", t), pin_err, 1);
      chk($sformatf("wrong%0d_tries", t), tries_left, 2 - t);
    end
    chk("lk_state", {state_dbg, locked}, {3'(S_LOCK), 1'b1});
    n = 1;
    while (locked && n < 200) begin
      if (n == 5) card_valid = 1'b0;
      step();
      if (locked) n++;
    end
    chk("lock_len", n, LOCK_T);
    chk("lk_exit", {state_dbg, tries_left}, {3'(S_IDLE), 2'd3});

    // Withdraw 50 with the ledger stalling; command must hold its captured values.
    card_valid = 1'b1;
    step();
    send_pin(16'h1234);
    chk("wd_menu", state_dbg, S_MENU);
    menu_sel = 3'b011; amount = 8'd50; menu_go = 1'b1; bus.cmd_ready = 1'b0;
    sb_q.push_back({2'b10, 8'd50});
    step();
    amount = 8'd99;
    chk("wd_cv", bus.cmd_valid, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("wd_hold%0d", k), {state_dbg, bus.cmd_valid, bus.cmd_op, bus.cmd_amount},
          {3'(S_ISSUE), 1'b1, 2'b10, 8'd50});
    end
    bus.cmd_ready = 1'b1;
    step();
    bus.cmd_ready = 1'b0;
    chk("wd_wait", {state_dbg, bus.cmd_valid}, {3'(S_WAIT), 1'b0});
    bus.rsp_valid = 1'b1; bus.rsp_ok = 1'b0;
    step();
    chk("wd_fail", {state_dbg, txn_fail, txn_ok}, {3'(S_MENU), 1'b1, 1'b0});

    // Idle in MENU until timeout.
    n = 0; seen = 1'b0;
    while (!seen && n < 3 * TO_T) begin
      step();
      n++;
      seen = timeout;
    end
    chk("menu_to_len", n, TO_T);
    chk("menu_to_state", state_dbg, S_END);
    card_valid = 1'b0;
    step();
    chk("menu_to_idle", state_dbg, S_IDLE);

    // A digit two cycles before expiry restarts the inactivity window.
    card_valid = 1'b1;
    step();
    repeat (TO_T - 2) step();
    digit_valid = 1'b1; digit = 4'd1;
    step();
    seen = 1'b0;
    for (int k = 0; k < TO_T - 1; k++) begin
      step();
      if (timeout) seen = 1'b1;
    end
    chk("pin_no_early_to", seen, 0);
    chk("pin_still_entry", state_dbg, S_PIN);
    step();
    chk("pin_to", {timeout, state_dbg}, {1'b1, 3'(S_END)});
    card_valid = 1'b0;
    step();

    // Card removed while waiting for the ledger response.
    card_valid = 1'b1;
    step();
    send_pin(16'h1234);
    menu_sel = 3'b001; menu_go = 1'b1; bus.cmd_ready = 1'b1;
    sb_q.push_back({2'b00, 8'd0});
    step();
    chk("cr_issue", state_dbg, S_ISSUE);
    step();
    bus.cmd_ready = 1'b0;
    card_valid = 1'b0;
    repeat (3) step();
    chk("cr_hold", {state_dbg, session_active}, {3'(S_WAIT), 1'b1});
    bus.rsp_valid = 1'b1; bus.rsp_ok = 1'b1;
    step();
    chk("cr_ok_end", {txn_ok, state_dbg}, {1'b1, 3'(S_END)});
    step();
    chk("cr_idle", state_dbg, S_IDLE);

    // Reset aborts lockout.
    card_valid = 1'b1;
    step();
    repeat (3) send_pin(16'h0000);
    repeat (3) step();
    chk("rl_locked", locked, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rl_clear", {locked, state_dbg, tries_left}, {1'b0, 3'(S_IDLE), 2'd3});
    card_valid = 1'b0;
    step();

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/atm_session_ctrl.md
# atm_session_ctrl

Session controller that sequences a customer session ahead of the balance/ledger datapath: card presence, 4-digit PIN entry with limited attempts and lockout, menu decode, and a valid/ready command handshake to the ledger. It sits between the board inputs (switches, debounced button pulses) and the ledger. The ledger only ever sees fully-authorised, one-at-a-time transactions.

## Interface
- PIN_VALUE, 16'h1234, expected PIN as 4 BCD digits, first entered digit in [15:12]
- MAX_TRIES, 3, wrong-PIN attempts before lockout (1..3)
- TIMEOUT_CYCLES, 50_000_000, inactivity limit in PIN_ENTRY/MENU
- LOCK_CYCLES, 100_000_000, lockout duration
- RAPID_AMOUNT, 8'd20, fixed amount for rapid withdraw
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- card_valid  in  1  level: valid card present
- digit_valid  in  1  one-cycle pulse, digit accepted
- digit  in  4  BCD digit (values >9 ignored)
- enter_btn, cancel_btn, menu_go  in  1 each  one-cycle pulses
- menu_sel  in  3  001 balance, 010 rapid withdraw, 011 withdraw, 100 deposit, 101 exit
- amount  in  8  amount for withdraw/deposit
- cmd_valid  out  1  command to ledger
- cmd_op  out  2  00 inquiry, 01 deposit, 10 withdraw
- cmd_amount  out  8  command amount
- cmd_ready  in  1  ledger accepts command
- rsp_valid, rsp_ok  in  1 each  ledger result pulse / success
- session_active, locked  out  1 each  levels
- pin_err, timeout, txn_ok, txn_fail  out  1 each  one-cycle pulses
- tries_left  out  2  remaining attempts
- state_dbg  out  3  current state encoding

## Operation
- States: IDLE, PIN_ENTRY, PIN_CHECK, MENU, ISSUE, WAIT_RSP, LOCKOUT, END.
- IDLE: when card_valid=1, clear the digit buffer and count, then go to PIN_ENTRY.
- PIN_ENTRY: each valid digit shifts into a 16-bit buffer and increments the count (0..4). Digits beyond the 4th are ignored.
  - cancel clears the buffer and count.
  - enter goes to PIN_CHECK.
- PIN_CHECK (one cycle):
  - Match requires count==4 and buffer==PIN_VALUE. On match: go to MENU and reload tries_left to MAX_TRIES.
  - On mismatch: pulse pin_err, decrement tries_left, clear buffer. If tries_left reaches 0, go to LOCKOUT; otherwise return to PIN_ENTRY.
- MENU, on menu_go:
  - 001 issues op 00 with amount 0.
  - 010 issues op 10 with RAPID_AMOUNT.
  - 011 issues op 10 with amount.
  - 100 issues op 01 with amount.
  - 101 goes to END.
  - Other codes, and 011/100 with amount==0, are ignored.
  - cancel goes to END.
- ISSUE: cmd_valid=1; cmd_op and cmd_amount are captured on entry and held stable until cmd_ready. The transfer completes in the cycle where cmd_valid&cmd_ready; then go to WAIT_RSP.
- WAIT_RSP: on rsp_valid, pulse txn_ok (rsp_ok=1) or txn_fail (rsp_ok=0), then go to MENU.
- LOCKOUT: locked=1. Count LOCK_CYCLES, then reload tries_left and go to IDLE. Card removal does not shorten the lockout.
- END: one cycle, then IDLE.
- Card removal (card_valid=0):
  - In PIN_ENTRY, PIN_CHECK or MENU: go to END.
  - In ISSUE or WAIT_RSP: the transaction completes first, then go to END instead of MENU.
- Inactivity counter, active in PIN_ENTRY and MENU only:
  - Clears on any digit_valid, enter_btn, cancel_btn or menu_go, and on state entry.
  - Reaching TIMEOUT_CYCLES-1 pulses timeout and goes to END.
- Same-cycle priority: card removal > cancel > enter/menu_go > digit > timeout.
- session_active=1 in PIN_ENTRY, PIN_CHECK, MENU, ISSUE, WAIT_RSP.

## Timing
- All outputs are registered.
- Reset values: cmd_valid=0, cmd_op=0, cmd_amount=0, session_active=0, locked=0, all pulses 0, tries_left=MAX_TRIES, state_dbg=IDLE. Reset also clears the buffer and counters.
- rst mid-operation aborts immediately, including LOCKOUT and any pending command.
- enter at cycle N: PIN_CHECK at N+1; MENU, or pin_err pulse, at N+2.
- menu_go at N: cmd_valid high from N+1. A zero-wait ledger (cmd_ready already high) completes the transfer at N+1.
- rsp_valid at N: txn_ok/txn_fail at N+1, MENU at N+1.
- Inputs are not sampled for state change during ISSUE, WAIT_RSP or LOCKOUT, except card removal as noted.

## Structure
- Shared package atm_pkg holds the state encoding, the cmd_op codes (OP_INQ, OP_DEP, OP_WDR) and the menu_sel codes.
- Sub-module atm_session_timer: a loadable down-counter with clear and done flag, instanced twice (inactivity and lockout).

## Test plan
- Card in, digits 1,2,3,4, enter -> MENU at enter+2, tries_left=3, no pin_err.
- Three wrong PINs (1,1,1,1 + enter, three times) -> pin_err three times, tries_left 2,1,0. Then locked=1 for LOCK_CYCLES, then IDLE with tries_left=3.
- MENU, menu_sel=011, amount=50, menu_go, cmd_ready held low 5 cycles -> cmd_valid/op=10/amount=50 stable all 5 cycles. rsp_valid&rsp_ok=0 -> txn_fail pulse, back to MENU.
- MENU, menu_sel=010 -> cmd_amount=20. menu_sel=100 with amount=0 -> no cmd_valid.
- No input in MENU for TIMEOUT_CYCLES -> timeout pulse, END, IDLE. A digit at TIMEOUT_CYCLES-2 in PIN_ENTRY -> no timeout.
- card_valid drops during WAIT_RSP -> stays until rsp_valid, then END/IDLE. rst during LOCKOUT -> locked=0 next cycle.
